// File: rtl/req_sched_pkg.sv
// Shared types and constants for the request scheduler.
// Used by req_sched and prio_enc16.
package req_sched_pkg;

   localparam int NUM_REQ = 16;
   localparam int IDX_W   = 4;
   localparam logic [7:0] NO_GRANT = 8'hF0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Rotate right so that bit (j + n) mod NUM_REQ lands on bit j.
   function automatic logic [NUM_REQ-1:0] rot_right(input logic [NUM_REQ-1:0] v,
                                                    input logic [IDX_W-1:0]   n);
      logic [2*NUM_REQ-1:0] dbl;
      dbl = {v, v} >> n;
      return dbl[NUM_REQ-1:0];
   endfunction

endpackage

// File: rtl/req_sched_prio.sv
// Combinational 16-input priority encoder.
// Reports the highest set bit and whether any bit is set.
module prio_enc16
   import req_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] vec,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

   // Later iterations overwrite earlier ones, so the highest set bit wins.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (vec[i]) begin
            idx   = i[IDX_W-1:0];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/req_sched.sv
// Request scheduler: latches level requests and grants one eligible source at a time.
// Define REQ_SCHED_RR_EN for rotating priority; otherwise the highest index wins.
module req_sched
   import req_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic [NUM_REQ-1:0]  req,
   input  logic [NUM_REQ-1:0]  mask,
   input  logic                grant_ack,
   output logic                grant_valid,
   output logic [7:0]          grant_idx,
   output logic                busy,
   output logic                timeout
);

   localparam logic [7:0] TO_LIM = TIMEOUT_CYCLES[7:0];

   state_t               state;
   state_t               state_nx;
   logic [NUM_REQ-1:0]   pending;
   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   enc_in;
   logic [NUM_REQ-1:0]   clr_vec;
   logic [IDX_W-1:0]     enc_idx;
   logic [IDX_W-1:0]     win_idx;
   logic                 enc_valid;
   logic [7:0]           cnt;
   logic [7:0]           cnt_nx;
   logic                 valid_nx;
   logic [7:0]           idx_nx;
   logic                 timeout_nx;
   logic                 expire;
   logic                 finish;

   assign eligible = pending & ~mask;

`ifdef REQ_SCHED_RR_EN
   logic [IDX_W-1:0] last;

   // Rotate so the search starts at last-1, then map the winner back.
   assign enc_in  = rot_right(eligible, last);
   assign win_idx = enc_idx + last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= '0;
      end else if (finish) begin
         last <= grant_idx[IDX_W-1:0];
      end
   end
`else
   assign enc_in  = eligible;
   assign win_idx = enc_idx;
`endif

   prio_enc16 u_enc (
      .vec   (enc_in),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      valid_nx   = 1'b0;
      idx_nx     = NO_GRANT;
      timeout_nx = 1'b0;
      expire     = 1'b0;
      finish     = 1'b0;
      clr_vec    = '0;
      case (state)
         IDLE: begin
            if (ena && enc_valid) begin
               state_nx = GRANT;
               valid_nx = 1'b1;
               idx_nx   = {{(8-IDX_W){1'b0}}, win_idx};
               cnt_nx   = 8'd0;
            end else begin
               state_nx = IDLE;
            end
         end
         GRANT: begin
            // An ack on the expiring cycle takes precedence over the timeout.
            expire = (TO_LIM != 8'd0) && ((cnt + 8'd1) == TO_LIM);
            finish = grant_ack || expire;
            if (finish) begin
               state_nx                      = DONE;
               clr_vec[grant_idx[IDX_W-1:0]] = 1'b1;
               timeout_nx                    = !grant_ack;
            end else begin
               state_nx = GRANT;
               valid_nx = 1'b1;
               idx_nx   = grant_idx;
               cnt_nx   = cnt + 8'd1;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // A request arriving on the clearing edge keeps its pending bit set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pending     <= '0;
         cnt         <= 8'd0;
         grant_valid <= 1'b0;
         grant_idx   <= NO_GRANT;
         busy        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nx;
         pending     <= (pending & ~clr_vec) | req;
         cnt         <= cnt_nx;
         grant_valid <= valid_nx;
         grant_idx   <= idx_nx;
         busy        <= (state_nx != IDLE);
         timeout     <= timeout_nx;
      end
   end

endmodule

// File: tb/tb_req_sched.sv
// Randomised scoreboard bench for req_sched with directed scenarios.
// Honours REQ_SCHED_RR_EN to select the reference arbitration rule.
module tb_req_sched;
   import req_sched_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ena = 1'b0;
   logic [15:0] req = 16'h0000;
   logic [15:0] mask = 16'h0000;
   logic        grant_ack = 1'b0;
   logic        grant_valid;
   logic [7:0]  grant_idx;
   logic        busy;
   logic        timeout;

   always #5 clk = ~clk;

   req_sched #(.TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .req         (req),
      .mask        (mask),
      .grant_ack   (grant_ack),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx),
      .busy        (busy),
      .timeout     (timeout)
   );

   int total = 0;
   int bad   = 0;
   int ncyc  = 0;

   always @(posedge clk) ncyc++;

   typedef struct {
      int idx;
      int t_start;
      int t_end;
      int timed;
   } ev_t;

   ev_t expq[$];

   // reference model: pending set, phase 0=idle 1=granting 2=cooldown
   bit [15:0] m_pend = 16'h0000;
   int m_phase = 0;
   int m_idx   = 0;
   int m_age   = 0;
   int m_start = 0;
   int m_last  = 0;
   int m_ackw  = 0;

   function automatic void chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, want, want, ncyc);
      end
   endfunction

   function automatic int m_pick(input bit [15:0] el);
`ifdef REQ_SCHED_RR_EN
      for (int k = 1; k <= 16; k++) begin
         int i;
         i = (m_last - k + 16) % 16;
         if (el[i]) return i;
      end
`else
      for (int i = 15; i >= 0; i--) begin
         if (el[i]) return i;
      end
`endif
      return -1;
   endfunction

   function automatic void m_reset();
      m_pend  = 16'h0000;
      m_phase = 0;
      m_last  = 0;
      m_age   = 0;
   endfunction

   // Advance the model across the coming rising edge using current inputs.
   function automatic void model_step();
      int now;
      bit [15:0] clr;
      ev_t e;
      now = ncyc + 1;
      clr = 16'h0000;
      case (m_phase)
         1: begin
            if (grant_ack || (TO != 0 && m_age + 1 == TO)) begin
               e.idx = m_idx; e.t_start = m_start; e.t_end = now;
               e.timed = grant_ack ? 0 : 1;
               expq.push_back(e);
               clr[m_idx] = 1'b1;
               m_last  = m_idx;
               m_phase = 2;
            end else begin
               m_age++;
            end
         end
         2: m_phase = 0;
         default: begin
            if (ena) begin
               int w;
               w = m_pick(m_pend & ~mask);
               if (w >= 0) begin
                  m_phase = 1; m_idx = w; m_age = 0; m_start = now;
                  m_ackw  = $urandom_range(0, 5);
               end
            end
         end
      endcase
      m_pend = (m_pend & ~clr) | req;
   endfunction

   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   task automatic wait_grant(input string nm, input int want, input int budget);
      for (int n = 0; n < budget && !grant_valid; n++) tick();
      chk(nm, grant_valid ? int'(grant_idx) : -1, want);
   endtask

   task automatic drain_grants(input int cycles);
      for (int n = 0; n < cycles; n++) begin
         grant_ack = (m_phase == 1);
         tick();
      end
      grant_ack = 1'b0;
   endtask

   // monitor: per-cycle invariants and grant-completion scoreboard
   initial begin
      bit pv;
      int st, cidx;
      ev_t e;
      pv = 1'b0; st = 0; cidx = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            pv = 1'b0;
         end else begin
            if (!grant_valid) chk("idle_idx", grant_idx, 8'hF0);
            chk("busy", busy, (grant_valid || pv) ? 1 : 0);
            if (grant_valid && !pv) begin
               st = ncyc; cidx = grant_idx;
            end else if (grant_valid && pv) begin
               chk("held_idx", grant_idx, cidx);
            end
            if (!grant_valid && pv) begin
               if (expq.size() == 0) begin
                  chk("unexpected_grant", 1, 0);
               end else begin
                  e = expq.pop_front();
                  chk("ev_idx", cidx, e.idx);
                  chk("ev_start", st, e.t_start);
                  chk("ev_end", ncyc, e.t_end);
                  chk("ev_timeout", timeout, e.timed);
               end
            end else begin
               chk("stray_timeout", timeout, 0);
            end
            pv = grant_valid;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_valid", grant_valid, 0);
      chk("rst_idx", grant_idx, 8'hF0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout, 0);
      rst = 1'b0;
      m_reset();
      for (int n = 0; n < 10; n++) begin
         tick();
         chk("idle10_valid", grant_valid, 0);
         chk("idle10_idx", grant_idx, 8'hF0);
         chk("idle10_busy", busy, 0);
      end
      ena = 1'b1;

`ifdef REQ_SCHED_RR_EN
      req = 16'hFFFF;
      for (int k = 0; k <= 16; k++) begin
         wait_grant("rr_order", (31 - k) % 16, 4);
         grant_ack = 1'b1; tick(); grant_ack = 1'b0;
      end
      req = 16'h0000;
      drain_grants(60);
`else
      req = 16'h2AF1;
      tick();
      chk("lat_not_yet", grant_valid, 0);
      tick();
      chk("lat_valid", grant_valid, 1);
      chk("first_idx", grant_idx, 8'h0D);
      req = 16'h0AF1; grant_ack = 1'b1; tick(); grant_ack = 1'b0;
      chk("done_valid", grant_valid, 0);
      chk("done_idx", grant_idx, 8'hF0);
      chk("done_busy", busy, 1);
      wait_grant("second_idx", 8'h0B, 4);
      req = 16'h0000;
      drain_grants(40);

      req = 16'h0001; tick(); req = 16'h0000;
      wait_grant("pulse_idx", 8'h00, 3);
      tick(); tick();
      chk("pulse_held", grant_valid, 1);
      grant_ack = 1'b1; tick(); grant_ack = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("pulse_cleared", grant_valid, 0);
      end

      req = 16'h8000; tick(); req = 16'h0000;
      wait_grant("to_idx", 8'h0F, 3);
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("to_waiting_valid", grant_valid, 1);
         chk("to_waiting_pulse", timeout, 0);
      end
      tick();
      chk("to_pulse", timeout, 1);
      chk("to_dropped", grant_valid, 0);
      chk("to_idx_back", grant_idx, 8'hF0);
      tick();
      chk("to_one_cycle", timeout, 0);
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("to_pending_cleared", grant_valid, 0);
      end

      mask = 16'h8000; req = 16'hFFFF; tick();
      wait_grant("mask_idx", 8'h0E, 3);
      mask = 16'hFFFF; req = 16'h0000;
      for (int n = 0; n < 2; n++) begin
         tick();
         chk("mask_held_idx", grant_idx, 8'h0E);
      end
      grant_ack = 1'b1; tick(); grant_ack = 1'b0;
      mask = 16'h0000;
      wait_grant("unmask_idx", 8'h0F, 4);
      drain_grants(80);
`endif

      req = 16'h0001; tick(); req = 16'h0000;
      wait_grant("mid_rst_grant", 8'h00, 3);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", grant_valid, 0);
      chk("mid_rst_idx", grant_idx, 8'hF0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_timeout", timeout, 0);
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("post_rst_idle", grant_valid, 0);
      end

      for (int n = 0; n < 800; n++) begin
         req  = 16'($urandom) & 16'($urandom) & 16'($urandom);
         mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
         ena  = ($urandom_range(0, 3) != 0);
         if (m_phase == 1) grant_ack = (m_age == m_ackw);
         else grant_ack = ($urandom_range(0, 7) == 0);
         tick();
      end

      req = 16'h0000; mask = 16'h0000; ena = 1'b0;
      drain_grants(20);
      tick();
      chk("queue_empty", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
